// File: rtl/mux3_rr_arb.sv
// mux3_rr_arb: round-robin arbiter driving the S1/S0 selects of a 3:1 data mux
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   V0..V2             source i has a valid word on mux input Di
//   Out_ready          downstream accepts the word this cycle
//   S1, S0             registered mux selects (00=D0, 01=D1, 10=D2, never 11)
//   Out_valid          mux output holds a valid word from the granted source
//   A0..A2             transfer strobe for source i
//   Busy               a grant is held
module mux3_rr_arb #(
   parameter int MAXB = 4,
   parameter int CW   = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic V0,
   input  logic V1,
   input  logic V2,
   input  logic Out_ready,
   output logic S0,
   output logic S1,
   output logic Out_valid,
   output logic A0,
   output logic A1,
   output logic A2,
   output logic Busy
);
   typedef enum logic {IDLE, GRANT} st_t;
   st_t st_q, st_d;
   logic [1:0] g_q, g_d, ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] v;
   logic xfer, last, any;
   function automatic logic [1:0] inc3(input logic [1:0] x);
      return x == 2'd2 ? 2'd0 : x + 2'd1;
   endfunction
   // first requester in cyclic order s, s+1, s+2
   function automatic logic [1:0] pick(input logic [1:0] s, input logic [2:0] m);
      logic [1:0] a, b;
      a = inc3(s);
      b = inc3(a);
      return m[s] ? s : m[a] ? a : b;
   endfunction
   assign v         = {V2, V1, V0};
   assign any       = |v;
   assign Busy      = st_q == GRANT;
   assign Out_valid = Busy && v[g_q];
   assign xfer      = Out_valid && Out_ready;
   assign last      = cnt_q == CW'(MAXB - 1);
   assign {S1, S0}  = g_q;
   assign A0        = xfer && g_q == 2'd0;
   assign A1        = xfer && g_q == 2'd1;
   assign A2        = xfer && g_q == 2'd2;
   always_comb begin
      st_d  = st_q;
      g_d   = g_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (st_q == IDLE) begin
         if (any) begin
            g_d   = pick(ptr_q, v);
            cnt_d = '0;
            st_d  = GRANT;
         end
      end else if (xfer && !last) begin
         cnt_d = cnt_q + CW'(1);
      end else if (xfer || !v[g_q]) begin
         // burst exhausted or source dropped: current grant gets lowest priority
         ptr_d = inc3(g_q);
         cnt_d = '0;
         if (any) g_d = pick(inc3(g_q), v);
         else st_d = IDLE;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= IDLE;
         g_q   <= 2'd0;
         ptr_q <= 2'd0;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         g_q   <= g_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_mux3_rr_arb.sv
// tb_mux3_rr_arb: checks mux3_rr_arb (MAXB=4 and MAXB=1) against vectors and a reference model
module tb_mux3_rr_arb;
   logic clk = 0, rst_n = 0, V0 = 0, V1 = 0, V2 = 0, Out_ready = 0;
   logic [3:0] s;
   logic [1:0] ov, busy;
   logic [5:0] a;
   int pass_n = 0, total_n = 0;
   always #5 clk = ~clk;
   mux3_rr_arb #(.MAXB(4), .CW(4)) dut (
      .clk(clk), .rst_n(rst_n), .V0(V0), .V1(V1), .V2(V2), .Out_ready(Out_ready),
      .S0(s[0]), .S1(s[1]), .Out_valid(ov[0]), .A0(a[0]), .A1(a[1]), .A2(a[2]), .Busy(busy[0])
   );
   mux3_rr_arb #(.MAXB(1), .CW(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .V0(V0), .V1(V1), .V2(V2), .Out_ready(Out_ready),
      .S0(s[2]), .S1(s[3]), .Out_valid(ov[1]), .A0(a[3]), .A1(a[4]), .A2(a[5]), .Busy(busy[1])
   );
   typedef struct {
      logic [2:0] v;
      logic       rdy;
      int         sel;
      logic       ov;
      logic [2:0] a;
      logic       busy;
   } vec_t;
   vec_t tbl[$];
   int m_st[2], m_g[2], m_ptr[2], m_cnt[2];
   int mb[2] = '{4, 1};
   task automatic chk(input string n, input int act, input int exp);
      total_n++;
      if (act == exp) pass_n++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", n, act, exp, $time);
   endtask
   task automatic add(input int n, input logic [2:0] v, input logic rdy, input int sel,
                      input logic o, input logic [2:0] aa, input logic b);
      vec_t r;
      r.v = v; r.rdy = rdy; r.sel = sel; r.ov = o; r.a = aa; r.busy = b;
      repeat (n) tbl.push_back(r);
   endtask
   function automatic int mpick(input int st, input logic [2:0] v);
      for (int k = 0; k < 3; k++) if (v[(st + k) % 3]) return (st + k) % 3;
      return -1;
   endfunction
   task automatic mreset();
      for (int i = 0; i < 2; i++) begin
         m_st[i] = 0; m_g[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0;
      end
   endtask
   // expected outputs from the model state and the present inputs
   task automatic chk_models();
      logic [2:0] v;
      int eov;
      v = {V2, V1, V0};
      for (int i = 0; i < 2; i++) begin
         eov = (m_st[i] == 1 && v[m_g[i]]) ? 1 : 0;
         chk($sformatf("m%0d_sel", i), int'(s[2*i +: 2]), m_g[i]);
         chk($sformatf("m%0d_ov", i), int'(ov[i]), eov);
         chk($sformatf("m%0d_a", i), int'(a[3*i +: 3]), (eov == 1 && Out_ready) ? (1 << m_g[i]) : 0);
         chk($sformatf("m%0d_busy", i), int'(busy[i]), m_st[i]);
      end
   endtask
   task automatic tick();
      logic [2:0] v;
      int n;
      bit x;
      @(posedge clk);
      v = {V2, V1, V0};
      for (int i = 0; i < 2; i++) begin
         if (m_st[i] == 0) begin
            if (v != 0) begin
               m_g[i] = mpick(m_ptr[i], v); m_cnt[i] = 0; m_st[i] = 1;
            end
         end else begin
            x = v[m_g[i]] && Out_ready;
            if (x && m_cnt[i] + 1 < mb[i]) m_cnt[i]++;
            else if (x || !v[m_g[i]]) begin
               n = mpick((m_g[i] + 1) % 3, v);
               m_ptr[i] = (m_g[i] + 1) % 3;
               m_cnt[i] = 0;
               if (n >= 0) m_g[i] = n;
               else m_st[i] = 0;
            end
         end
      end
   endtask
   task automatic drive(input logic [2:0] v, input logic rdy);
      @(negedge clk);
      {V2, V1, V0} = v;
      Out_ready = rdy;
      #1;
   endtask
   initial begin
      int seq1[4] = '{0, 2, 0, 2};
      mreset();
      add(1, 3'b010, 1, 0, 0, 3'b000, 0);
      add(5, 3'b010, 1, 1, 1, 3'b010, 1);
      add(3, 3'b111, 1, 1, 1, 3'b010, 1);
      add(4, 3'b111, 1, 2, 1, 3'b100, 1);
      add(4, 3'b111, 1, 0, 1, 3'b001, 1);
      add(4, 3'b111, 1, 1, 1, 3'b010, 1);
      add(1, 3'b111, 1, 2, 1, 3'b100, 1);
      add(5, 3'b101, 0, 2, 1, 3'b000, 1);
      add(3, 3'b101, 1, 2, 1, 3'b100, 1);
      add(1, 3'b001, 1, 0, 1, 3'b001, 1);
      add(1, 3'b100, 1, 0, 0, 3'b000, 1);
      add(1, 3'b000, 1, 2, 0, 3'b000, 1);
      add(1, 3'b000, 1, 2, 0, 3'b000, 0);
      add(1, 3'b111, 0, 2, 0, 3'b000, 0);
      add(1, 3'b111, 0, 0, 1, 3'b000, 1);
      repeat (2) @(negedge clk);
      chk("rst_sel", int'(s[1:0]), 0);
      chk("rst_ov", int'(ov[0]), 0);
      chk("rst_busy", int'(busy[0]), 0);
      rst_n = 1;
      foreach (tbl[k]) begin
         drive(tbl[k].v, tbl[k].rdy);
         chk($sformatf("tbl%0d_sel", k), int'(s[1:0]), tbl[k].sel);
         chk($sformatf("tbl%0d_ov", k), int'(ov[0]), int'(tbl[k].ov));
         chk($sformatf("tbl%0d_a", k), int'(a[2:0]), int'(tbl[k].a));
         chk($sformatf("tbl%0d_busy", k), int'(busy[0]), int'(tbl[k].busy));
         chk_models();
         tick();
      end
      // asynchronous reset in the middle of a grant to source 1
      drive(3'b010, 1);
      tick();
      drive(3'b010, 0);
      chk("pre_rst_sel", int'(s[1:0]), 1);
      chk_models();
      #2 rst_n = 0;
      #1;
      chk("arst_sel", int'(s[1:0]), 0);
      chk("arst_ov", int'(ov[0]), 0);
      chk("arst_a", int'(a[2:0]), 0);
      chk("arst_busy", int'(busy[0]), 0);
      mreset();
      chk_models();
      {V2, V1, V0} = 3'b101;
      Out_ready = 1;
      @(negedge clk);
      rst_n = 1;
      #1;
      chk("rel_busy", int'(busy[0]), 0);
      chk_models();
      tick();
      // MAXB=1 instance alternates between the two requesters
      for (int k = 0; k < 4; k++) begin
         drive(3'b101, 1);
         chk($sformatf("rr1_sel%0d", k), int'(s[3:2]), seq1[k]);
         chk($sformatf("rr1_a%0d", k), int'(a[5:3]), 1 << seq1[k]);
         if (k == 0) chk("rst_first_grant", int'(s[1:0]), 0);
         chk_models();
         tick();
      end
      for (int k = 0; k < 1500; k++) begin
         drive(3'($urandom_range(0, 7)), ($urandom % 4) != 0);
         chk_models();
         tick();
      end
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule

// File: doc/mux3_rr_arb.md
# mux3_rr_arb

Round-robin arbiter that generates the S1/S0 select pair for the team's 3:1 data mux. Three sources present valid requests. The block grants one source at a time, drives the selects so the mux routes that source, and runs a valid/ready handshake with the downstream consumer. A per-grant burst limit stops one source from starving the others.

## Interface
Parameters:
- MAXB, default 4: maximum consecutive transfers per grant while other sources are requesting. Legal range 1..15.
- CW, default 4: burst counter width. Must satisfy 2^CW > MAXB.

Ports (clock and reset first):
- clk, input, 1: single clock. All state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- V0, V1, V2, input, 1 each: source i has a word valid on mux input Di.
- Out_ready, input, 1: downstream consumer accepts the word this cycle.
- S0, S1, output, 1 each: registered mux selects.
  - S1S0 = 00 selects D0.
  - S1S0 = 01 selects D1.
  - S1S0 = 10 selects D2. The block never drives 11.
- Out_valid, output, 1: the mux output holds a valid word from the granted source.
- A0, A1, A2, output, 1 each: transfer strobe for source i this cycle. The source advances its data on the edge where Ai = 1.
- Busy, output, 1: a grant is held (state GRANT).

## Operation
Registered state:
- st: IDLE or GRANT.
- g: granted source, 0..2. Drives {S1,S0} directly.
- ptr: round-robin search start, 0..2.
- cnt: transfers completed in the current grant, CW bits.

Combinational outputs:
- Out_valid = (st == GRANT) && V[g].
- Ai = Out_valid && Out_ready && (g == i).
- Busy = (st == GRANT).
- The paths V/Out_ready -> Out_valid/Ai are intentional, with zero latency.

Round-robin pick, pick(start, mask): the first requesting source in the order start, start+1, start+2 (mod 3).

IDLE:
- If any Vi = 1: g <= pick(ptr, all requesters), cnt <= 0, st <= GRANT.
- Otherwise stay in IDLE. Selects hold their last value.

GRANT, evaluated every cycle. Let xfer = Out_valid && Out_ready.
- If xfer and cnt+1 < MAXB: cnt <= cnt+1, stay on g.
- If xfer and cnt+1 == MAXB (burst exhausted): rearbitrate, with g as the lowest priority.
  - g <= pick(g+1, V), cnt <= 0, ptr <= g+1 (mod 3).
  - If only g is requesting, g is regranted with cnt reset.
  - If no source is requesting, st <= IDLE and ptr <= g+1.
- If V[g] = 0 (no xfer): release.
  - If other sources are requesting: handover in the same edge, using the same rearbitration rule with pick(g+1, V). No bubble.
  - Otherwise: st <= IDLE, ptr <= g+1.
- The grant never changes while Out_valid = 1 and Out_ready = 0.

Source rule: a source must hold Vi high until Ai. If it drops early, the grant is released per the rule above and no strobe is issued.

## Timing
- Reset (asynchronous assert) sets: st = IDLE, g = 0 (S1S0 = 00), ptr = 0, cnt = 0. Outputs: Out_valid = 0, A0..A2 = 0, Busy = 0.
- Reset asserted mid-burst: the grant is lost immediately and the outputs go to their reset values in the same cycle.
- Reset release: the first grant can occur at the first rising edge after rst_n goes high.
- Request-to-valid latency from IDLE: 1 cycle. A Vi sampled at edge k gives new selects and Out_valid = 1 after edge k.
- Handover between sources: 0 bubble cycles. A new source's Out_valid can be high in the cycle right after the last transfer of the previous grant.
- Sustained throughput: 1 transfer per cycle while Out_ready = 1.
- Simultaneous requests from IDLE: the source at ptr wins first. Other sources follow in cyclic order.
- MAXB = 1: every transfer rearbitrates, giving pure per-word round robin.
- Burst counter: cnt never exceeds MAXB-1 and cannot wrap, since 2^CW > MAXB.

## Test plan
- Reset, single request:
  - Stimulus: hold V1 = 1 with Out_ready = 1; release rst_n.
  - Required: S1S0 = 01 one cycle after the first edge. A1 pulses every cycle. After 4 transfers, g is regranted to 1 with no gap.
- Three-way contention:
  - Stimulus: MAXB = 4; V0 = V1 = V2 = 1 continuously; Out_ready = 1.
  - Required grant order: 0 ×4, 1 ×4, 2 ×4, 0 ×4. No idle cycles.
- Backpressure:
  - Stimulus: granted to 2; Out_ready = 0 for 5 cycles; V0 = 1 throughout.
  - Required: S1S0 stays 10 and Out_valid stays 1. A2 = 0 and cnt is unchanged. The transfer resumes when Out_ready returns.
- Early release:
  - Stimulus: granted to 0 with cnt = 1; V0 drops; V2 = 1.
  - Required: next cycle g = 2 with cnt = 0, then ptr = 1. With no other requester, st = IDLE.
- Async reset mid-burst:
  - Stimulus: assert rst_n low between edges during a grant to 1.
  - Required: S1S0 = 00, Out_valid = 0, A1 = 0 and Busy = 0 immediately. After release, arbitration restarts from ptr = 0.
- MAXB = 1 with V0 and V2 requesting:
  - Required: grants alternate 0, 2, 0, 2. S1S0 is never 11.
